mdu_ctrl: RTL and testbench

//   Multiply/divide unit and its sequencer for the pipelined MIPS CPU. Accepts

---
 rtl/mdu_ctrl.sv | 149 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the pipelined MIPS core: owns HI/LO and holds a
// fixed busy window per mult/div so the hazard unit can stall dependents.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic        md_read,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int DATA_W = 32;
    localparam int MAXC   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W  = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2:0]          op_p0;
    logic [DATA_W-1:0]   a_p0, b_p0;
    logic                accept, load, is_mul_p0, div_zero_p0;
    logic [2*DATA_W-1:0] res_p1;

    // Full product; zero extension keeps the signed multiply correct for multu.
    function automatic logic [2*DATA_W-1:0] mul_full(input logic sgn,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] sa, sb;
        sa = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        sb = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        return sa * sb;
    endfunction

    // Returns {remainder, quotient}. Signed case divides magnitudes, so
    // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of trapping.
    function automatic logic [2*DATA_W-1:0] div_full(input logic sgn,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic              neg_a, neg_b;
        logic [DATA_W-1:0] ua, ub, uq, ur, q, r;
        neg_a = sgn & a[DATA_W-1];
        neg_b = sgn & b[DATA_W-1];
        ua    = neg_a ? -a : a;
        ub    = neg_b ? -b : b;
        if (ub == '0) begin
            uq = '0;
            ur = '0;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
        end
        q = (neg_a ^ neg_b) ? -uq : uq;
        r = neg_a ? -ur : ur;
        return {r, q};
    endfunction

    assign busy      = (state_q == ST_BUSY);
    assign stall_req = busy & (op_valid | md_read);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign accept    = op_valid & ~busy & (op >= OP_MULT) & (op <= OP_MTLO);

    // Stage p1: result formed from the latched operands, consumed at commit
    assign is_mul_p0   = (op_p0 == OP_MULT) | (op_p0 == OP_MULTU);
    assign div_zero_p0 = ~is_mul_p0 & (b_p0 == '0);
    assign res_p1      = is_mul_p0 ? mul_full(op_p0 == OP_MULT, a_p0, b_p0)
                                   : div_full(op_p0 == OP_DIV, a_p0, b_p0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            load    = 1'b1;
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            load    = 1'b1;
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (!div_zero_p0) begin
                        {hi_d, lo_d} = res_p1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stage p0: operand/op capture at accept
    always_ff @(posedge clk) begin
        if (load) begin
            op_p0 <= op;
            a_p0  <= rs_val;
            b_p0  <= rt_val;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, corner sequences, random ops
// against an arithmetic reference model.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        md_read = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .md_read(md_read), .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one command for a single cycle, then count busy cycles (bounded).
    task automatic run_op(input logic v, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        @(negedge clk);
        op_valid = v; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the ISA definitions.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l, output int n);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        n = 0;
        case (o)
            3'd1: begin p = sa * sb; {h, l} = p; n = MC; end
            3'd2: begin up = ua * ub; {h, l} = up; n = MC; end
            3'd3: begin
                n = DC;
                if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
            end
            3'd4: begin
                n = DC;
                if (b != 0) begin l = 32'(ua / ub); h = 32'(ua % ub); end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endtask

    initial begin
        int n, guard;
        logic [2:0] ro;
        logic [31:0] ra, rb;
        int en;

        vecs[0]  = '{1'b1, 3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1]  = '{1'b1, 3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC};
        vecs[2]  = '{1'b1, 3'd3, 32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFE, DC};
        vecs[3]  = '{1'b1, 3'd4, 32'd7,        32'd0,        32'hFFFFFFFE, 32'hFFFFFFFE, DC};
        vecs[4]  = '{1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[5]  = '{1'b1, 3'd7, 32'h11111111, 32'h2,        32'h00000000, 32'h80000000, 0};
        vecs[6]  = '{1'b0, 3'd1, 32'h3,        32'h4,        32'h00000000, 32'h80000000, 0};
        vecs[7]  = '{1'b1, 3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC};
        vecs[8]  = '{1'b1, 3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[9]  = '{1'b1, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
        vecs[10] = '{1'b1, 3'd5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00000000, 0};
        vecs[11] = '{1'b1, 3'd0, 32'h12345678, 32'h1,        32'hDEADBEEF, 32'h00000000, 0};

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        md_read = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        md_read = 1'b0;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, n);
            check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].n));
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end
        mhi = 32'hDEADBEEF; mlo = 32'h0;

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        op_valid = 1'b1; op = 3'd5; rs_val = 32'hAAAA5555;
        @(negedge clk);
        check("mthi_hi", hi, 32'hAAAA5555);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd6; rs_val = 32'h5555AAAA;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        check("mtlo_lo", lo, 32'h5555AAAA);
        check("mtlo_hi", hi, 32'hAAAA5555);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        mhi = 32'hAAAA5555; mlo = 32'h5555AAAA;

        // Stall while busy; held MTLO accepted after busy falls
        @(negedge clk);
        op_valid = 1'b1; op = 3'd1; rs_val = 32'd5; rt_val = 32'd7;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0; md_read = 1'b1;
        #1;
        check("mdread_stall", {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        md_read = 1'b0; op_valid = 1'b1; op = 3'd6; rs_val = 32'h1234;
        #1;
        check("op_stall", {31'd0, stall_req}, 32'd1);
        guard = 0;
        while (busy && guard < 50) begin
            check("lo_hold", lo, mlo);
            @(negedge clk);
            #1;
            guard++;
        end
        check("stall_release", {31'd0, stall_req}, 32'd0);
        check("held_mult_lo", lo, 32'd35);
        check("held_mult_hi", hi, 32'd0);
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        check("held_mtlo_lo", lo, 32'h1234);
        check("held_mtlo_busy", {31'd0, busy}, 32'd0);
        md_read = 1'b1;
        #1;
        check("idle_mdread_nostall", {31'd0, stall_req}, 32'd0);
        md_read = 1'b0;

        // Reset in the middle of a div
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd3;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        repeat (3) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        repeat (15) @(negedge clk);
        check("nocommit_hi", hi, 32'd0);
        check("nocommit_lo", lo, 32'd0);
        check("nocommit_busy", {31'd0, busy}, 32'd0);
        mhi = '0; mlo = '0;

        // Random ops against the model
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(1, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            model(ro, ra, rb, mhi, mlo, en);
            run_op(1'b1, ro, ra, rb, n);
            check($sformatf("rnd%0d_op%0d_cycles", k, ro), 32'(n), 32'(en));
            check($sformatf("rnd%0d_op%0d_hi", k, ro), hi, mhi);
            check($sformatf("rnd%0d_op%0d_lo", k, ro), lo, mlo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
